// File: rtl/vertex_projector.sv
// vertex_projector: applies a snapshotted 4x4 fixed-point matrix to (x,y,z,1), then divides by w to produce NDC.
// Latency: out_valid rises 15 clock edges after the accept edge (12 MAC cycles + 3 divide cycles).
// Backpressure: in_ready is low from accept until the output handshake; the result holds while out_ready is low.
module vertex_projector #(
  parameter int WI = 8,
  parameter int WF = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [15:0][WI+WF-1:0] projection_matrix,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WI+WF-1:0]       in_x,
  input  logic [WI+WF-1:0]       in_y,
  input  logic [WI+WF-1:0]       in_z,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WI+WF-1:0]       out_x,
  output logic [WI+WF-1:0]       out_y,
  output logic [WI+WF-1:0]       out_z,
  output logic                   out_clip,
  output logic                   out_sat
);
  localparam int W  = WI + WF;
  localparam int PW = 2 * W;
  localparam int AW = PW + 2;      // two guard bits over a full-width product
  localparam int DW = W + WF + 2;  // holds 2*|num<<WF| + |den| without overflow

  localparam logic signed [AW-1:0] HALF = AW'(1) <<< (WF - 1);
  localparam logic signed [AW-1:0] SMAX = AW'((1 << (W - 1)) - 1);
  localparam logic signed [AW-1:0] SMIN = ~SMAX;
  localparam logic [W-1:0]         WMAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]         WMIN = {1'b1, {(W-1){1'b0}}};
  localparam logic [DW-1:0]        QMAX = DW'((1 << (W - 1)) - 1);
  localparam logic [DW-1:0]        QNEG = QMAX + DW'(1);

  typedef enum logic [1:0] {IDLE, MAC, DIV, DONE} state_t;

  state_t               r_state;
  logic [15:0][W-1:0]   r_m;
  logic [2:0][W-1:0]    r_v;
  logic [3:0][W-1:0]    r_c;
  logic signed [AW-1:0] r_acc;
  logic [1:0]           r_row;
  logic [1:0]           r_col;
  logic [1:0]           r_dcnt;

  logic signed [W-1:0]  w_coef;
  logic signed [W-1:0]  w_trans;
  logic signed [W-1:0]  w_vcoord;
  logic signed [PW-1:0] w_prod;
  logic signed [AW-1:0] w_base;
  logic signed [AW-1:0] w_sum;
  logic signed [AW-1:0] w_biased;
  logic signed [AW-1:0] w_rnd;
  logic                 w_row_ovf;
  logic [W-1:0]         w_row_val;

  logic signed [W-1:0]  w_dnum;
  logic signed [W-1:0]  w_dden;
  logic signed [DW-1:0] w_nsx;
  logic signed [DW-1:0] w_dsx;
  logic [DW-1:0]        w_nabs;
  logic [DW-1:0]        w_dabs;
  logic [DW-1:0]        w_n2;
  logic [DW-1:0]        w_d2;
  logic [DW-1:0]        w_qabs;
  logic                 w_qneg;
  logic                 w_q_ovf;
  logic [W-1:0]         w_q_val;
  logic                 w_cw_zero;

  // Shared multiplier and row accumulator; the column-0 step preloads the translation term m[r][3]
  always_comb begin
    w_coef   = r_m[{r_row, r_col}];
    w_trans  = r_m[{r_row, 2'd3}];
    case (r_col)
      2'd0:    w_vcoord = r_v[0];
      2'd1:    w_vcoord = r_v[1];
      default: w_vcoord = r_v[2];
    endcase
    w_prod    = w_coef * w_vcoord;
    w_base    = (r_col == 2'd0) ? (AW'(w_trans) <<< WF) : r_acc;
    w_sum     = w_base + AW'(w_prod);
    // Subtracting one for negative sums makes the half-LSB bias round ties away from zero
    w_biased  = w_sum + HALF - AW'(w_sum[AW-1]);
    w_rnd     = w_biased >>> WF;
    w_row_ovf = (w_rnd > SMAX) || (w_rnd < SMIN);
    w_row_val = (w_rnd > SMAX) ? WMAX : (w_rnd < SMIN) ? WMIN : w_rnd[W-1:0];
  end

  // Sign-magnitude rounding divider: |q| = (2|n|*2^WF + |d|) / (2|d|), then reapply the sign
  always_comb begin
    case (r_dcnt)
      2'd0:    w_dnum = r_c[0];
      2'd1:    w_dnum = r_c[1];
      default: w_dnum = r_c[2];
    endcase
    w_dden    = r_c[3];
    w_nsx     = DW'(w_dnum);
    w_dsx     = DW'(w_dden);
    w_nabs    = w_nsx[DW-1] ? -w_nsx : w_nsx;
    w_dabs    = w_dsx[DW-1] ? -w_dsx : w_dsx;
    w_n2      = (w_nabs << (WF + 1)) + w_dabs;
    w_d2      = w_dabs << 1;
    w_qabs    = (w_d2 == '0) ? '0 : (w_n2 / w_d2);
    w_qneg    = w_dnum[W-1] ^ w_dden[W-1];
    w_q_ovf   = w_qneg ? (w_qabs > QNEG) : (w_qabs > QMAX);
    w_q_val   = w_qneg ? (~w_qabs[W-1:0] + W'(1)) : w_qabs[W-1:0];
    if (w_q_ovf) begin
      w_q_val = w_qneg ? WMIN : WMAX;
    end
    w_cw_zero = (w_dden == '0);
  end

  // Control FSM: accept/snapshot, 12 MAC steps, 3 divide steps, then hold the result until taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_m       <= '0;
      r_v       <= '0;
      r_c       <= '0;
      r_acc     <= '0;
      r_row     <= '0;
      r_col     <= '0;
      r_dcnt    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
      out_z     <= '0;
      out_clip  <= 1'b0;
      out_sat   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_m      <= projection_matrix;
            r_v      <= {in_z, in_y, in_x};
            r_row    <= '0;
            r_col    <= '0;
            out_clip <= 1'b0;
            out_sat  <= 1'b0;
            in_ready <= 1'b0;
            r_state  <= MAC;
          end
        end
        MAC: begin
          r_acc <= w_sum;
          if (r_col == 2'd2) begin
            r_c[r_row] <= w_row_val;
            if (w_row_ovf) out_sat <= 1'b1;
            r_col <= '0;
            if (r_row == 2'd3) begin
              r_dcnt  <= '0;
              r_state <= DIV;
            end else begin
              r_row <= r_row + 2'd1;
            end
          end else begin
            r_col <= r_col + 2'd1;
          end
        end
        DIV: begin
          if (w_cw_zero) begin
            out_clip <= 1'b1;
          end else if (w_q_ovf) begin
            out_sat <= 1'b1;
          end
          case (r_dcnt)
            2'd0:    out_x <= w_cw_zero ? '0 : w_q_val;
            2'd1:    out_y <= w_cw_zero ? '0 : w_q_val;
            default: out_z <= w_cw_zero ? '0 : w_q_val;
          endcase
          r_dcnt <= r_dcnt + 2'd1;
          if (r_dcnt == 2'd2) begin
            out_valid <= 1'b1;
            r_state   <= DONE;
          end
        end
        default: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            r_state   <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vertex_projector.sv
`timescale 1ns/1ps
// Bench for vertex_projector: fixed vectors, backpressure and reset sequences, then random vertices vs an integer model.
module tb_vertex_projector;
  typedef logic [15:0][15:0] mat_t;
  typedef struct {
    mat_t        m;
    logic [15:0] x, y, z, ex, ey, ez;
    logic        ec, es;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  mat_t        projection_matrix;
  logic        in_valid, in_ready, out_valid, out_ready, out_clip, out_sat;
  logic [15:0] in_x, in_y, in_z, out_x, out_y, out_z;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  vertex_projector #(.WI(8), .WF(8)) dut (
    .clk(clk), .rst_n(rst_n), .projection_matrix(projection_matrix),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_z(in_z),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_z(out_z),
    .out_clip(out_clip), .out_sat(out_sat)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic mat_t ident();
    mat_t m = '0;
    m[0] = 16'h0100; m[5] = 16'h0100; m[10] = 16'h0100; m[15] = 16'h0100;
    return m;
  endfunction

  // Round-to-nearest integer quotient, ties away from zero
  function automatic longint rdiv(input longint n, input longint d);
    longint an, ad, q;
    an = (n < 0) ? -n : n;
    ad = (d < 0) ? -d : d;
    q  = (2 * an + ad) / (2 * ad);
    return ((n < 0) != (d < 0)) ? -q : q;
  endfunction

  function automatic logic [15:0] sat16(input longint v, inout logic f);
    longint t;
    t = v;
    if (t > 32767) begin t = 32767; f = 1'b1; end
    if (t < -32768) begin t = -32768; f = 1'b1; end
    return t[15:0];
  endfunction

  // Reference: real-valued matrix product and divide expressed in integer units of 2^-8
  function automatic void model(input mat_t m, input logic [15:0] x, y, z,
                                output logic [15:0] ox, oy, oz, output logic oc, os);
    longint v[3];
    longint cs[4];
    longint s;
    logic   sat;
    v[0] = longint'($signed(x));
    v[1] = longint'($signed(y));
    v[2] = longint'($signed(z));
    sat = 1'b0;
    for (int row = 0; row < 4; row++) begin
      s = longint'($signed(m[row*4+3])) * 256;
      for (int col = 0; col < 3; col++) s += longint'($signed(m[row*4+col])) * v[col];
      cs[row] = longint'($signed(sat16(rdiv(s, 256), sat)));
    end
    oc = (cs[3] == 0);
    if (oc) begin
      ox = '0; oy = '0; oz = '0;
    end else begin
      ox = sat16(rdiv(cs[0] * 256, cs[3]), sat);
      oy = sat16(rdiv(cs[1] * 256, cs[3]), sat);
      oz = sat16(rdiv(cs[2] * 256, cs[3]), sat);
    end
    os = sat;
  endfunction

  // Called at a negedge; returns at the negedge after the accept edge with the matrix bus changed
  task automatic accept_vtx(input mat_t m, input mat_t m_after, input logic [15:0] x, y, z);
    int t = 0;
    projection_matrix = m; in_x = x; in_y = y; in_z = z; in_valid = 1'b1;
    while (!in_ready && t < 100) begin @(negedge clk); t++; end
    check("accept_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    projection_matrix = m_after;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 60) begin @(posedge clk); lat++; @(negedge clk); end
  endtask

  task automatic finish_out();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic run_vertex(input string tag, input mat_t m, input mat_t m_after,
                            input logic [15:0] x, y, z, ex, ey, ez, input logic ec, es, input int hold);
    int lat;
    accept_vtx(m, m_after, x, y, z);
    wait_valid(lat);
    check({tag, "_latency"}, lat, 32'd15);
    for (int i = 0; i < hold; i++) begin @(posedge clk); @(negedge clk); end
    check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    check({tag, "_x"}, out_x, ex);
    check({tag, "_y"}, out_y, ey);
    check({tag, "_z"}, out_z, ez);
    check({tag, "_clip"}, {31'b0, out_clip}, {31'b0, ec});
    check({tag, "_sat"}, {31'b0, out_sat}, {31'b0, es});
    check({tag, "_in_ready_busy"}, {31'b0, in_ready}, 32'd0);
    finish_out();
  endtask

  initial begin
    vec_t        tbl[8];
    mat_t        mp, mz, mbig, mdiv, mneg, mhalf, mr, mscr;
    logic [15:0] ex, ey, ez, vx, vy, vz, hx, hy, hz;
    logic        ec, es;
    int          lat, seen;

    mp = '0; mp[0] = 16'h0100; mp[5] = 16'h0100; mp[10] = 16'hFEC7; mp[11] = 16'h0239; mp[14] = 16'h0100;
    mz = ident(); mz[15] = 16'h0000;
    mbig = ident(); mbig[0] = 16'h7F00;
    mdiv = ident(); mdiv[15] = 16'h0010;
    mneg = ident(); mneg[15] = 16'hFF00;
    mhalf = ident(); mhalf[0] = 16'h0080; mhalf[5] = 16'h0080; mhalf[10] = 16'h0080;
    for (int k = 0; k < 16; k++) mscr[k] = 16'h5A5A ^ 16'(k * 4099);

    tbl[0] = '{ident(), 16'h0100, 16'h0200, 16'h0300, 16'h0100, 16'h0200, 16'h0300, 1'b0, 1'b0};
    tbl[1] = '{mp,      16'h0100, 16'h0100, 16'hFE00, 16'hFF80, 16'hFF80, 16'hFDAA, 1'b0, 1'b0};
    tbl[2] = '{mz,      16'h0100, 16'h0200, 16'h0300, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0};
    tbl[3] = '{mbig,    16'h0200, 16'h0100, 16'h0100, 16'h7FFF, 16'h0100, 16'h0100, 1'b0, 1'b1};
    tbl[4] = '{ident(), 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 1'b0, 1'b0};
    tbl[5] = '{mdiv,    16'h1000, 16'h0000, 16'h0000, 16'h7FFF, 16'h0000, 16'h0000, 1'b0, 1'b1};
    tbl[6] = '{mneg,    16'h0100, 16'hFE00, 16'h0080, 16'hFF00, 16'h0200, 16'hFF80, 1'b0, 1'b0};
    tbl[7] = '{mhalf,   16'h0001, 16'hFFFF, 16'h0003, 16'h0001, 16'hFFFF, 16'h0002, 1'b0, 1'b0};

    in_valid = 1'b0; out_ready = 1'b0; projection_matrix = '0;
    in_x = '0; in_y = '0; in_z = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_in_ready", {31'b0, in_ready}, 32'd1);
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("reset_out_x", out_x, 32'd0);
    check("reset_out_y", out_y, 32'd0);
    check("reset_out_z", out_z, 32'd0);
    check("reset_clip", {31'b0, out_clip}, 32'd0);
    check("reset_sat", {31'b0, out_sat}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Fixed vectors; the matrix bus is scrambled right after each accept
    for (int i = 0; i < 8; i++) begin
      run_vertex($sformatf("tbl%0d", i), tbl[i].m, mscr, tbl[i].x, tbl[i].y, tbl[i].z,
                 tbl[i].ex, tbl[i].ey, tbl[i].ez, tbl[i].ec, tbl[i].es, 0);
    end

    // Output held under backpressure while a second vertex waits; it enters one bubble after the handshake
    accept_vtx(ident(), ident(), 16'h0100, 16'h0200, 16'h0300);
    wait_valid(lat);
    check("bp_latency", lat, 32'd15);
    projection_matrix = mp; in_x = 16'h0100; in_y = 16'h0100; in_z = 16'hFE00; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("bp_hold%0d_in_ready", i), {31'b0, in_ready}, 32'd0);
      check($sformatf("bp_hold%0d_valid", i), {31'b0, out_valid}, 32'd1);
      check($sformatf("bp_hold%0d_x", i), out_x, 32'h0100);
      check($sformatf("bp_hold%0d_z", i), out_z, 32'h0300);
    end
    finish_out();
    check("bp_bubble_valid", {31'b0, out_valid}, 32'd0);
    check("bp_bubble_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_second_accepted", {31'b0, in_ready}, 32'd0);
    wait_valid(lat);
    check("bp_second_latency", lat, 32'd15);
    check("bp_second_x", out_x, 32'hFF80);
    check("bp_second_z", out_z, 32'hFDAA);
    finish_out();

    // Reset during MAC aborts the vertex
    accept_vtx(ident(), ident(), 16'h0100, 16'h0200, 16'h0300);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_mid_out_valid", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("rst_abort_no_valid", seen, 32'd0);
    check("rst_abort_in_ready", {31'b0, in_ready}, 32'd1);

    // Random vertices against the model
    for (int i = 0; i < 40; i++) begin
      for (int k = 0; k < 16; k++) begin
        if ($urandom_range(0, 9) == 0) mr[k] = 16'($urandom);
        else mr[k] = 16'($urandom_range(0, 2047)) - 16'd1024;
        mscr[k] = 16'($urandom);
      end
      if (i % 8 == 3) for (int k = 12; k < 16; k++) mr[k] = '0;
      vx = 16'($urandom_range(0, 8191)) - 16'd4096;
      vy = 16'($urandom_range(0, 8191)) - 16'd4096;
      vz = 16'($urandom_range(0, 8191)) - 16'd4096;
      if (i % 5 == 0) vx = 16'($urandom);
      model(mr, vx, vy, vz, ex, ey, ez, ec, es);
      hx = ex; hy = ey; hz = ez;
      run_vertex($sformatf("rnd%0d", i), mr, mscr, vx, vy, vz, hx, hy, hz, ec, es,
                 int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
